// File: rtl/vram_bus_arbiter.sv
// rtl/vram_bus_arbiter.sv - VRAM bus sequencer sharing two-cycle accesses between PPU, OAM DMA and CPU
module vram_bus_arbiter #(
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic        clk1,
    input  logic        nreset,
    input  logic        render,
    input  logic        ppu_req,
    input  logic [12:0] ppu_addr,
    output logic        ppu_ack,
    input  logic        dma_req,
    input  logic [12:0] dma_addr,
    output logic        dma_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    input  logic [7:0]  md_in,
    output logic [7:0]  rdata,
    output logic [12:0] ma_out,
    output logic [7:0]  md_out,
    output logic        md_oe,
    output logic        nmcs,
    output logic        nmoe,
    output logic        nmwr,
    output logic [1:0]  grant
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_PPU  = 2'd1;
    localparam logic [1:0] G_DMA  = 2'd2;
    localparam logic [1:0] G_CPU  = 2'd3;
    localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

    state_t      state, state_next;
    logic        wr_q, wr_next;
    logic [7:0]  wait_cnt, wait_next;
    logic [1:0]  win, grant_next;
    logic [12:0] ma_next;
    logic [7:0]  md_next, rdata_next;
    logic        finishing, lockout, boost;
    logic        ppu_ok, dma_ok, cpu_ok;
    logic        ppu_ack_next, dma_ack_next, cpu_ack_next;

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        wr_next      = wr_q;
        ma_next      = ma_out;
        md_next      = md_out;
        rdata_next   = rdata;
        wait_next    = wait_cnt;
        win          = G_NONE;

        finishing = (state == DATA);
        // The owner finishing this edge sits out one arbitration round
        ppu_ok = ppu_req && !(finishing && grant == G_PPU);
        dma_ok = dma_req && !(finishing && grant == G_DMA);
        cpu_ok = cpu_req && !render && !(finishing && grant == G_CPU);
        boost  = (wait_cnt == MAX_WAIT);

        if (state == IDLE || finishing) begin
            if (ppu_ok)
                win = G_PPU;
            else if (cpu_ok && boost)
                win = G_CPU;
            else if (dma_ok)
                win = G_DMA;
            else if (cpu_ok)
                win = G_CPU;
        end

        // Lockout acks wait out a bus-ack edge so two acks never coincide
        lockout = cpu_req && render && (grant != G_CPU) && !cpu_ack && !finishing;

        ppu_ack_next = finishing && (grant == G_PPU);
        dma_ack_next = finishing && (grant == G_DMA);
        cpu_ack_next = (finishing && (grant == G_CPU)) || lockout;

        if (finishing && !wr_q)
            rdata_next = md_in;
        else if (lockout)
            rdata_next = 8'hFF;

        if (!cpu_req || render || win == G_CPU || grant == G_CPU)
            wait_next = 8'd0;
        else if (wait_cnt < MAX_WAIT)
            wait_next = wait_cnt + 8'd1;

        if (win != G_NONE) begin
            state_next = ADDR;
            grant_next = win;
            wr_next    = (win == G_CPU) && cpu_we;
            case (win)
                G_PPU:   ma_next = ppu_addr;
                G_DMA:   ma_next = dma_addr;
                default: ma_next = cpu_addr;
            endcase
            if (win == G_CPU)
                md_next = cpu_wdata;
        end else if (state == ADDR) begin
            state_next = DATA;
        end else begin
            state_next = IDLE;
            grant_next = G_NONE;
        end
    end

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            grant    <= G_NONE;
            wr_q     <= 1'b0;
            wait_cnt <= 8'd0;
            ma_out   <= 13'd0;
            md_out   <= 8'd0;
            rdata    <= 8'hFF;
            ppu_ack  <= 1'b0;
            dma_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            nmcs     <= 1'b1;
            nmoe     <= 1'b1;
            nmwr     <= 1'b1;
            md_oe    <= 1'b0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            wr_q     <= wr_next;
            wait_cnt <= wait_next;
            ma_out   <= ma_next;
            md_out   <= md_next;
            rdata    <= rdata_next;
            ppu_ack  <= ppu_ack_next;
            dma_ack  <= dma_ack_next;
            cpu_ack  <= cpu_ack_next;
            nmcs     <= (state_next == IDLE);
            nmoe     <= !((state_next == DATA) && !wr_next);
            nmwr     <= !((state_next == DATA) && wr_next);
            md_oe    <= (state_next == DATA) && wr_next;
        end
    end
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// tb/tb_vram_bus_arbiter.sv - directed and randomized bench for vram_bus_arbiter against a transaction model
module tb_vram_bus_arbiter;
    localparam int MAXW = 8;

    logic        clk1 = 1'b0;
    logic        nreset = 1'b0;
    logic        render = 1'b0;
    logic        ppu_req = 1'b0, dma_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [12:0] ppu_addr = '0, dma_addr = '0, cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0, md_in = '0;
    logic        ppu_ack, dma_ack, cpu_ack, md_oe, nmcs, nmoe, nmwr;
    logic [7:0]  rdata, md_out;
    logic [12:0] ma_out;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner 0..3, phase 0 idle / 1 address / 2 data
    int          m_own, m_ph, m_cnt;
    bit          m_we, e_pa, e_da, e_ca;
    logic [12:0] m_addr;
    logic [7:0]  m_wd, m_rd;

    vram_bus_arbiter #(.CPU_MAX_WAIT(MAXW)) dut (
        .clk1(clk1), .nreset(nreset), .render(render),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .md_in(md_in),
        .rdata(rdata), .ma_out(ma_out), .md_out(md_out), .md_oe(md_oe),
        .nmcs(nmcs), .nmoe(nmoe), .nmwr(nmwr), .grant(grant)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_own = 0; m_ph = 0; m_cnt = 0; m_we = 0;
        e_pa = 0; e_da = 0; e_ca = 0;
        m_addr = '0; m_wd = '0; m_rd = 8'hFF;
    endtask

    task automatic model_edge();
        int done, pick;
        bit el_p, el_d, el_c, lock;
        done = (m_ph == 2) ? m_own : 0;
        el_p = ppu_req && done != 1;
        el_d = dma_req && done != 2;
        el_c = cpu_req && !render && done != 3;
        pick = 0;
        if (m_ph != 1) begin
            if (el_p) pick = 1;
            else if (el_c && m_cnt == MAXW) pick = 3;
            else if (el_d) pick = 2;
            else if (el_c) pick = 3;
        end
        lock = cpu_req && render && m_own != 3 && !e_ca && done == 0;
        if (done != 0 && !m_we) m_rd = md_in;
        else if (lock) m_rd = 8'hFF;
        e_pa = (done == 1);
        e_da = (done == 2);
        e_ca = (done == 3) || lock;
        if (cpu_req && !render && pick != 3 && m_own != 3)
            m_cnt = (m_cnt < MAXW) ? m_cnt + 1 : MAXW;
        else
            m_cnt = 0;
        if (pick != 0) begin
            m_own = pick;
            m_ph = 1;
            m_we = (pick == 3) && cpu_we;
            m_addr = (pick == 1) ? ppu_addr : (pick == 2) ? dma_addr : cpu_addr;
            if (pick == 3) m_wd = cpu_wdata;
        end else if (m_ph == 1) begin
            m_ph = 2;
        end else begin
            m_ph = 0;
            m_own = 0;
        end
    endtask

    task automatic compare_all();
        chk("grant", 32'(grant), 32'(m_own));
        chk("nmcs", 32'(nmcs), 32'(m_ph == 0));
        chk("nmoe", 32'(nmoe), 32'(!(m_ph == 2 && !m_we)));
        chk("nmwr", 32'(nmwr), 32'(!(m_ph == 2 && m_we)));
        chk("md_oe", 32'(md_oe), 32'(m_ph == 2 && m_we));
        chk("acks", 32'({ppu_ack, dma_ack, cpu_ack}), 32'({e_pa, e_da, e_ca}));
        if (e_pa || e_da || e_ca) chk("rdata", 32'(rdata), 32'(m_rd));
        if (m_ph != 0) chk("ma_out", 32'(ma_out), 32'(m_addr));
        if (m_ph == 2 && m_we) chk("md_out", 32'(md_out), 32'(m_wd));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk1);
        #1;
        compare_all();
        if (ppu_ack) ppu_req = 1'b0;
        if (dma_ack) dma_req = 1'b0;
        if (cpu_ack) cpu_req = 1'b0;
    endtask

    initial begin
        int ppu_at, dma_at, cpu_at, gaps, dma_after;
        reset_model();
        repeat (2) @(posedge clk1);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_nmcs", 32'(nmcs), 32'd1);
        chk("rst_strobes", 32'({nmoe, nmwr, md_oe}), 32'b110);
        chk("rst_rdata", 32'(rdata), 32'hFF);
        chk("rst_ma_md", 32'({ma_out, md_out}), 32'd0);
        chk("rst_acks", 32'({ppu_ack, dma_ack, cpu_ack}), 32'd0);
        nreset = 1'b1;

        // CPU read on an idle bus
        cpu_addr = 13'h0123; cpu_we = 1'b0; cpu_req = 1'b1; md_in = 8'h5A;
        step();
        chk("t1_e1_grant", 32'(grant), 32'd3);
        chk("t1_e1_nmcs", 32'(nmcs), 32'd0);
        step();
        chk("t1_e2_nmoe", 32'(nmoe), 32'd0);
        step();
        chk("t1_ack", 32'(cpu_ack), 32'd1);
        chk("t1_rdata", 32'(rdata), 32'h5A);
        step();

        // All three requesters at once: back-to-back, no idle gap
        ppu_addr = 13'h1111; dma_addr = 13'h0222; cpu_addr = 13'h0333;
        ppu_req = 1'b1; dma_req = 1'b1; cpu_req = 1'b1; md_in = 8'hC3;
        ppu_at = 0; dma_at = 0; cpu_at = 0; gaps = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (ppu_ack) ppu_at = e;
            if (dma_ack) dma_at = e;
            if (cpu_ack) cpu_at = e;
            if (e <= 6 && nmcs) gaps++;
        end
        chk("t2_ppu_edge", 32'(ppu_at), 32'd3);
        chk("t2_dma_edge", 32'(dma_at), 32'd5);
        chk("t2_cpu_edge", 32'(cpu_at), 32'd7);
        chk("t2_no_gap", 32'(gaps), 32'd0);

        // Write during render is dropped and acked at once
        render = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0456; cpu_wdata = 8'h77;
        cpu_req = 1'b1; md_in = 8'h3C;
        step();
        chk("t3_lock_ack", 32'(cpu_ack), 32'd1);
        chk("t3_lock_rdata", 32'(rdata), 32'hFF);
        chk("t3_no_wr", 32'(nmwr), 32'd1);
        step();
        render = 1'b0; cpu_we = 1'b0; cpu_req = 1'b1;
        repeat (3) step();
        chk("t3_readback", 32'(rdata), 32'h3C);
        step();

        // CPU starved by PPU/DMA traffic until its wait counter saturates
        ppu_req = 1'b1; dma_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
        cpu_addr = 13'h0777; md_in = 8'h42;
        cpu_at = 0; dma_after = 0;
        for (int e = 1; e <= 24; e++) begin
            bool_step: begin
                bit pa, da;
                step();
                pa = ppu_ack; da = dma_ack;
                if (cpu_ack) cpu_at = e;
                if (da && cpu_at != 0 && dma_after == 0) dma_after = e;
                if (e < 16 && !ppu_req && !pa) ppu_req = 1'b1;
                if (e < 16 && !dma_req && !da) dma_req = 1'b1;
            end
        end
        chk("t4_cpu_boost_edge", 32'(cpu_at), 32'd13);
        chk("t4_dma_resumes", 32'(dma_after), 32'd17);

        // Asynchronous reset in the data phase of a DMA read
        dma_addr = 13'h1ABC; dma_req = 1'b1;
        step();
        step();
        chk("t5_in_data", 32'(nmoe), 32'd0);
        #3;
        nreset = 1'b0;
        #1;
        chk("t5_async_nmcs", 32'(nmcs), 32'd1);
        chk("t5_async_nmoe", 32'(nmoe), 32'd1);
        chk("t5_async_grant", 32'(grant), 32'd0);
        reset_model();
        @(posedge clk1);
        #1;
        chk("t5_no_ack", 32'(dma_ack), 32'd0);
        nreset = 1'b1;
        step();
        chk("t5_regrant", 32'(grant), 32'd2);
        step();
        step();
        chk("t5_ack", 32'(dma_ack), 32'd1);
        step();

        // Render rising while a CPU access is in its address phase
        cpu_addr = 13'h0A0A; cpu_we = 1'b0; cpu_req = 1'b1; md_in = 8'h99;
        step();
        render = 1'b1;
        step();
        step();
        chk("t6_ack", 32'(cpu_ack), 32'd1);
        chk("t6_rdata", 32'(rdata), 32'h99);
        step();
        cpu_req = 1'b1;
        step();
        chk("t6_lock_ack", 32'(cpu_ack), 32'd1);
        chk("t6_lock_rdata", 32'(rdata), 32'hFF);
        render = 1'b0;
        step();

        // Random compliant requesters
        for (int i = 0; i < 800; i++) begin
            md_in = 8'($urandom);
            if ($urandom_range(0, 15) == 0) render = ~render;
            if (!ppu_req && !ppu_ack && $urandom_range(0, 3) == 0) begin
                ppu_req = 1'b1; ppu_addr = 13'($urandom);
            end
            if (!dma_req && !dma_ack && $urandom_range(0, 3) == 0) begin
                dma_req = 1'b1; dma_addr = 13'($urandom);
            end
            if (!cpu_req && !cpu_ack && $urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom);
                cpu_addr = 13'($urandom); cpu_wdata = 8'($urandom);
            end
            step();
        end
        for (int i = 0; i < 20; i++) step();
        chk("drain_idle", 32'({ppu_req, dma_req, cpu_req, nmcs}), 32'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vram_bus_arbiter.md
Name: vram_bus_arbiter

Overview:
- Sequences the external/video RAM bus (ma, md, nmcs/nmoe/nmwr) and shares it between three requesters: PPU fetcher, OAM DMA (VRAM source) and CPU.
- Sits between the requesters and the VRAM pin/bus logic.
- Runs fixed two-cycle bus accesses with fixed priority PPU > DMA > CPU, plus a CPU anti-starvation boost.
- While the PPU is rendering, CPU VRAM access is locked out the same way real hardware does it: reads return 0xFF and writes are dropped.

Parameters:
- CPU_MAX_WAIT, 8: cycles a pending, eligible CPU request may lose to DMA before it is promoted above DMA (1..255).

Ports:
- clk1  in  1  system clock; all state updates on rising edge.
- nreset  in  1  asynchronous active-low reset.
- render  in  1  PPU pixel-transfer active; locks out the CPU.
- ppu_req  in  1  PPU fetch request (read only).
- ppu_addr  in  13  PPU address.
- ppu_ack  out  1  one-cycle completion pulse to the PPU.
- dma_req  in  1  DMA read request.
- dma_addr  in  13  DMA address.
- dma_ack  out  1  one-cycle completion pulse to the DMA.
- cpu_req  in  1  CPU request.
- cpu_we  in  1  CPU access is a write.
- cpu_addr  in  13  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- md_in  in  8  VRAM read data.
- rdata  out  8  read data; valid in the cycle any ack is high.
- ma_out  out  13  VRAM address.
- md_out  out  8  VRAM write data.
- md_oe  out  1  drive md_out onto the bus.
- nmcs  out  1  chip select, active low.
- nmoe  out  1  output enable, active low.
- nmwr  out  1  write strobe, active low.
- grant  out  2  current owner: 0 none, 1 PPU, 2 DMA, 3 CPU.

Behaviour:
- Reset values (asynchronous, during nreset=0 and until the first edge after release):
  - state IDLE, grant 0, all acks 0.
  - nmcs=nmoe=nmwr=1, md_oe=0.
  - ma_out=0, md_out=0, rdata=0xFF, CPU wait counter 0.
- Reset mid-access aborts the access with no ack issued.
- States:
  - IDLE: bus idle, nmcs=1.
  - ADDR: nmcs=0, ma_out valid, no strobe.
  - DATA: nmcs=0; nmoe=0 for a read, or nmwr=0 with md_oe=1 for a write.
- Arbitration is performed at an edge in IDLE, or at the DATA->next edge for back-to-back accesses.
  - The winner's address (and CPU we/wdata) is latched into ma_out/md_out, grant is set, and next state is ADDR.
  - With no eligible requester, next state is IDLE and grant is 0.
- Eligibility:
  - The CPU is eligible only when render=0.
  - At the DATA->next edge the current grantee is excluded from that arbitration (its req is still high), so it cannot be re-granted immediately.
- Priority: PPU > DMA > CPU.
  - Exception: CPU > DMA when the wait counter == CPU_MAX_WAIT.
  - The PPU is never preempted by the boost.
- Wait counter:
  - Increments each edge when cpu_req=1, render=0 and the CPU is not granted; saturates at CPU_MAX_WAIT.
  - Clears on CPU grant, or whenever cpu_req=0 or render=1.
- Access sequence: ADDR (1 cycle) -> DATA (1 cycle).
  - At the DATA->next edge, a read captures md_in into rdata.
  - The owner's ack pulses high for exactly one cycle after that edge.
  - Latency is 3 edges from an idle-bus req to ack.
- Requesters hold req/addr/data stable until ack, and drop req in the ack cycle.
- Render lockout:
  - If cpu_req=1 and render=1 while the CPU is not granted, cpu_ack pulses one cycle later with rdata=0xFF. No bus cycle runs and writes are discarded.
  - Repeats every 2 cycles while req stays high; a compliant CPU drops req on ack.
  - This does not disturb an in-progress PPU/DMA access. rdata=0xFF is driven only in the lockout-ack cycle.
- render rising during a granted CPU access: that access completes normally.
- Simultaneous acks are impossible; at most one ack is high per cycle.
- grant and nmcs change only on clock edges; strobes are glitch-free, registered outputs.

Test Plan:
- CPU read, idle bus, render=0, cpu_addr=0x0123, md_in=0x5A:
  - nmcs low edges 1-2, nmoe low in DATA.
  - cpu_ack at edge 3 with rdata=0x5A, grant=3 during the access.
- ppu_req, dma_req and cpu_req (render=0) raised together:
  - Order PPU, DMA, CPU; back-to-back with no IDLE gap.
  - Acks at edges 3, 5, 7.
- CPU write with render=1, cpu_we=1, cpu_wdata=0x77:
  - cpu_ack one cycle later; nmwr never low; rdata=0xFF in the ack cycle.
  - A later render=0 read of the same address returns the pre-existing md_in value.
- Starvation, dma_req held continuously (re-asserted after each ack), cpu_req held, render=0, CPU_MAX_WAIT=8:
  - The CPU is granted once its counter reaches 8.
  - DMA resumes afterwards; the counter returns to 0.
- nreset asserted mid-DATA of a DMA read:
  - nmcs/nmoe go high immediately (asynchronous); no dma_ack; grant=0.
  - After release, a held dma_req restarts a full ADDR/DATA sequence.
- render rising during a CPU ADDR cycle:
  - The access completes with normal data and cpu_ack.
  - The next cpu_req is answered by a lockout ack with rdata 0xFF.
